bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that feeds the 6-digit display drivers. It accepts a binary value over a valid/ready handshake and returns DIGITS packed BCD digits, a leading-zero blanking mask and an overflow flag. A one-cycle result strobe marks each new result, and outputs hold until the next conversion completes. The display drivers then index digits directly instead of using `%` and `/` logic.

---
 rtl/bin2bcd_seq.sv | 123 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: shift-and-add-3 binary to packed BCD, one bit per clock.
// Produces leading-zero blanking and saturates to all nines on overflow.
module bin2bcd_seq #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    in_bin,
  output logic                out_valid,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic [DIGITS-1:0]   out_blank,
  output logic                out_ovf
);

  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  function automatic logic [BIN_W+3:0] max_val();
    logic [BIN_W+3:0] p;
    p = (BIN_W+4)'(1);
    for (int i = 0; i < DIGITS; i++)
      p = p * (BIN_W+4)'(10);
    return p - (BIN_W+4)'(1);
  endfunction

  localparam logic [BIN_W+3:0] MAXV = max_val();

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [BIN_W-1:0]  sreg;
  logic [AW-1:0]     acc;
  logic [AW-1:0]     adj;
  logic [CW-1:0]     cnt;
  logic              ovf_pend;
  logic [DIGITS-1:0] blank;
  logic              zrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = SHIFT;
      SHIFT:   if (cnt == CW'(BIN_W - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  // nibble-local +3 correction, no carry between digits
  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++)
      if (acc[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
  end

  always_comb begin
    blank = '0;
    zrun  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zrun     = zrun & (acc[4*i +: 4] == 4'd0);
      blank[i] = zrun;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg     <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sreg     <= in_bin;
          acc      <= '0;
          cnt      <= '0;
          ovf_pend <= ({4'b0, in_bin} > MAXV);
        end
        SHIFT: begin
          acc  <= {adj[AW-2:0], sreg[BIN_W-1]};
          sreg <= {sreg[BIN_W-2:0], 1'b0};
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_bcd   <= '0;
      out_blank <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= (state == DONE);
      if (state == DONE) begin
        out_bcd   <= ovf_pend ? {DIGITS{4'h9}} : acc;
        out_blank <= ovf_pend ? '0 : blank;
        out_ovf   <= ovf_pend;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq against a
// decimal reference model.
module tb_bin2bcd_seq;

  logic        clk_50M;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_bin;
  logic        out_valid;
  logic [23:0] out_bcd;
  logic [5:0]  out_blank;
  logic        out_ovf;

  bin2bcd_seq #(.BIN_W(20), .DIGITS(6)) dut (
    .clk       (clk_50M),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_bcd   (out_bcd),
    .out_blank (out_blank),
    .out_ovf   (out_ovf)
  );

  typedef struct {
    logic [23:0] bcd;
    logic [5:0]  blank;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk;
  int          n_pass;
  int          cyc;
  int          n_acc;
  int          last_acc;
  logic [30:0] last_out;

  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input int unsigned v, input int c);
    exp_t        e;
    int unsigned p;
    e.cyc = c;
    e.bcd = '0;
    e.blank = '0;
    e.ovf = 1'b0;
    if (v > 999999) begin
      e.bcd = 24'h999999;
      e.ovf = 1'b1;
    end else begin
      p = 1;
      for (int i = 0; i < 6; i++) begin
        e.bcd[4*i +: 4] = 4'((v / p) % 10);
        e.blank[i] = (i > 0) && (v < p);
        p = p * 10;
      end
    end
    return e;
  endfunction

  always @(posedge clk_50M) begin
    cyc++;
    if (rst_n && in_valid && in_ready) begin
      sb.push_back(model(in_bin, cyc));
      n_acc++;
      last_acc = cyc;
    end
  end

  always @(negedge clk_50M) begin
    exp_t e;
    if (!rst_n) begin
      last_out = '0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("bcd", out_bcd, e.bcd);
        chk("blank", out_blank, e.blank);
        chk("ovf", out_ovf, e.ovf);
        chk("latency", cyc - e.cyc, 21);
      end
      last_out = {out_bcd, out_blank, out_ovf};
    end else begin
      chk("stable", {out_bcd, out_blank, out_ovf}, last_out);
    end
  end

  task automatic wait_acc(input int s);
    for (int k = 0; k < 100 && n_acc == s; k++) @(negedge clk_50M);
    if (n_acc == s) chk("accept_timeout", 0, 1);
  endtask

  task automatic send(input logic [19:0] v);
    int s;
    s = n_acc;
    @(negedge clk_50M);
    in_valid = 1'b1;
    in_bin   = v;
    wait_acc(s);
    in_valid = 1'b0;
    in_bin   = 20'($urandom);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk_50M);
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(negedge clk_50M);
  endtask

  initial begin
    int s;
    int t1;
    logic [19:0] dir [6];
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    n_acc = 0;
    last_acc = 0;
    last_out = '0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_bin = '0;
    repeat (3) @(negedge clk_50M);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_bcd", out_bcd, 0);
    chk("rst_blank", out_blank, 0);
    chk("rst_ovf", out_ovf, 0);
    #2 rst_n = 1'b1;

    dir = '{20'd123456, 20'd0, 20'd42, 20'd999999, 20'd1000000, 20'd1048575};
    foreach (dir[i]) begin
      send(dir[i]);
      drain();
    end

    // held valid: second accept exactly one period later
    @(negedge clk_50M);
    s = n_acc;
    in_valid = 1'b1;
    in_bin = 20'd7;
    wait_acc(s);
    t1 = last_acc;
    in_bin = 20'd12345;
    repeat (10) @(negedge clk_50M);
    in_bin = 20'd80;
    s = n_acc;
    wait_acc(s);
    chk("accept_gap", last_acc - t1, 22);
    in_valid = 1'b0;
    drain();

    // reset mid-conversion aborts without a result
    send(20'd654321);
    repeat (5) @(negedge clk_50M);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    chk("abort_valid", out_valid, 0);
    chk("abort_bcd", out_bcd, 0);
    chk("abort_blank", out_blank, 0);
    chk("abort_ovf", out_ovf, 0);
    chk("abort_ready", in_ready, 1);
    @(negedge clk_50M);
    #2 rst_n = 1'b1;
    repeat (30) @(negedge clk_50M);
    send(20'd10);
    drain();

    for (int i = 0; i < 2500; i++)
      send(20'($urandom));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
